vga_pattern_gen: RTL and testbench

//  Parametrised VGA test-pattern source feeding pixel_color into the DE0_VGA driver.

---
 rtl/vga_pkg.sv | 48 ++++
 rtl/vga_bar_counter.sv | 53 +++++
 rtl/vga_pattern_gen.sv | 211 +++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator: mode encodings,
// the eight-entry colour-bar table and the per-channel on/off colour type.
package vga_pkg;

    // Pattern modes, in the order they are selected by mode_sel.
    typedef enum logic [2:0] {
        MODE_SOLID    = 3'd0,
        MODE_VBARS    = 3'd1,
        MODE_HBARS    = 3'd2,
        MODE_CHECKER  = 3'd3,
        MODE_GRADIENT = 3'd4,
        MODE_BOX      = 3'd5,
        MODE_CYCLE    = 3'd6,
        MODE_BLACK    = 3'd7
    } mode_e;

    // Box travel direction along one axis.
    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    // Colour with each channel either fully off or at full scale.
    // The generator widens each bit to CW bits.
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_on_t;

    // Bar colours in classic order: white, yellow, cyan, green,
    // magenta, red, blue, black.
    function automatic rgb_on_t color_table(input logic [2:0] idx);
        rgb_on_t c;
        case (idx)
            3'd0:    c = '{r: 1'b1, g: 1'b1, b: 1'b1};
            3'd1:    c = '{r: 1'b1, g: 1'b1, b: 1'b0};
            3'd2:    c = '{r: 1'b0, g: 1'b1, b: 1'b1};
            3'd3:    c = '{r: 1'b0, g: 1'b1, b: 1'b0};
            3'd4:    c = '{r: 1'b1, g: 1'b0, b: 1'b1};
            3'd5:    c = '{r: 1'b1, g: 1'b0, b: 1'b0};
            3'd6:    c = '{r: 1'b0, g: 1'b0, b: 1'b1};
            default: c = '{r: 1'b0, g: 1'b0, b: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_bar_counter.sv
// Divider-free colour-bar index for one screen axis. The coordinate is
// expected to count up by one (x) or stay constant and then step (y); the
// index is tracked by comparing against the next bar boundary. The idx
// output is combinational and belongs to the coordinate presented this cycle.
module vga_bar_counter #(
    parameter int W        = 11,
    parameter int ACTIVE   = 1024,
    parameter int NUM_BARS = 8,
    parameter int IW       = $clog2(NUM_BARS)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic [W-1:0]  coord,
    output logic [IW-1:0] idx
);

    localparam int            STEP     = ACTIVE / NUM_BARS;
    // Boundary register is one bit wider than the coordinate so that
    // adding STEP near the end of the line can never wrap.
    localparam logic [W:0]    STEP_E   = (W + 1)'(STEP);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_BARS - 1);

    logic [IW-1:0] idx_q, idx_d;
    logic [W:0]    nedge_q, nedge_d;

    // Restart at coordinate 0, advance one bar on each boundary, saturate
    // on the last bar so it absorbs the division remainder.
    always_comb begin
        idx_d   = idx_q;
        nedge_d = nedge_q;
        if (coord == '0) begin
            idx_d   = '0;
            nedge_d = STEP_E;
        end else if (({1'b0, coord} == nedge_q) && (idx_q != IDX_LAST)) begin
            idx_d   = idx_q + IW'(1);
            nedge_d = nedge_q + STEP_E;
        end
    end

    assign idx = idx_d;

    // Bar state register.
    always_ff @(posedge clk) begin
        if (srst) begin
            idx_q   <= '0;
            nedge_q <= STEP_E;
        end else begin
            idx_q   <= idx_d;
            nedge_q <= nedge_d;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source. Produces a registered colour one cycle after the
// pixel coordinate, switches pattern only on the rising edge of v_blank so a
// frame is never split between two patterns, and animates a bouncing box.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int CW       = 4,
    parameter int XW       = 11,
    parameter int YW       = 11,
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter int NUM_BARS = 8,
    parameter int CHK_LOG2 = 5,
    parameter int BOX_SIZE = 64,
    parameter int BOX_STEP = 4,
    parameter int FCW      = 8
) (
    input  logic            pixel_clk,
    input  logic            rst,
    input  logic [XW-1:0]   x_pix,
    input  logic [YW-1:0]   y_pix,
    input  logic            h_blank,
    input  logic            v_blank,
    input  logic [2:0]      mode_sel,
    input  logic [3*CW-1:0] user_color,
    output logic [3*CW-1:0] pixel_color,
    output logic [2:0]      mode_active,
    output logic [FCW-1:0]  frame_cnt
);

    localparam int IW = $clog2(NUM_BARS);

    // Box travel limits and sizes, one bit wider than the coordinates.
    localparam logic [XW:0] BX_MAX  = (XW + 1)'(H_ACTIVE - BOX_SIZE);
    localparam logic [YW:0] BY_MAX  = (YW + 1)'(V_ACTIVE - BOX_SIZE);
    localparam logic [XW:0] BX_STEP = (XW + 1)'(BOX_STEP);
    localparam logic [YW:0] BY_STEP = (YW + 1)'(BOX_STEP);
    localparam logic [XW:0] BX_SIZE = (XW + 1)'(BOX_SIZE);
    localparam logic [YW:0] BY_SIZE = (YW + 1)'(BOX_SIZE);

    typedef struct packed {
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
    } color_t;

    // Widen an on/off colour to full-scale channels.
    function automatic color_t expand(input rgb_on_t m);
        color_t c;
        c.r = {CW{m.r}};
        c.g = {CW{m.g}};
        c.b = {CW{m.b}};
        return c;
    endfunction

    logic           v_blank_q;
    logic           frame_edge;
    mode_e          mode_active_q, mode_active_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [XW-1:0]  bx_q, bx_d;
    logic [YW-1:0]  by_q, by_d;
    dir_e           dx_q, dx_d;
    dir_e           dy_q, dy_d;
    logic [XW:0]    bx_sum;
    logic [YW:0]    by_sum;
    color_t         pixel_q, pixel_d;
    color_t         pix_color;
    logic [IW-1:0]  x_idx, y_idx;
    logic [7:0]     x_ext, y_ext;
    logic           in_box;

    vga_bar_counter #(
        .W        (XW),
        .ACTIVE   (H_ACTIVE),
        .NUM_BARS (NUM_BARS),
        .IW       (IW)
    ) u_bar_x (
        .clk   (pixel_clk),
        .srst  (rst),
        .coord (x_pix),
        .idx   (x_idx)
    );

    vga_bar_counter #(
        .W        (YW),
        .ACTIVE   (V_ACTIVE),
        .NUM_BARS (NUM_BARS),
        .IW       (IW)
    ) u_bar_y (
        .clk   (pixel_clk),
        .srst  (rst),
        .coord (y_pix),
        .idx   (y_idx)
    );

    assign frame_edge = v_blank & ~v_blank_q;

    // Mode latch and frame counter only move on a frame edge.
    always_comb begin
        mode_active_d = mode_active_q;
        frame_cnt_d   = frame_cnt_q;
        if (frame_edge) begin
            mode_active_d = mode_e'(mode_sel);
            frame_cnt_d   = frame_cnt_q + FCW'(1);
        end
    end

    // Box motion: each axis bounces independently, clamping at both walls.
    always_comb begin
        bx_d   = bx_q;
        by_d   = by_q;
        dx_d   = dx_q;
        dy_d   = dy_q;
        bx_sum = {1'b0, bx_q} + BX_STEP;
        by_sum = {1'b0, by_q} + BY_STEP;
        if (frame_edge) begin
            if (dx_q == DIR_NEG) begin
                if ({1'b0, bx_q} < BX_STEP) begin
                    bx_d = '0;
                    dx_d = DIR_POS;
                end else begin
                    bx_d = bx_q - BX_STEP[XW-1:0];
                end
            end else if (bx_sum > BX_MAX) begin
                bx_d = BX_MAX[XW-1:0];
                dx_d = DIR_NEG;
            end else begin
                bx_d = bx_sum[XW-1:0];
            end

            if (dy_q == DIR_NEG) begin
                if ({1'b0, by_q} < BY_STEP) begin
                    by_d = '0;
                    dy_d = DIR_POS;
                end else begin
                    by_d = by_q - BY_STEP[YW-1:0];
                end
            end else if (by_sum > BY_MAX) begin
                by_d = BY_MAX[YW-1:0];
                dy_d = DIR_NEG;
            end else begin
                by_d = by_sum[YW-1:0];
            end
        end
    end

    // Box state register, kept separate from the datapath flops.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            bx_q <= '0;
            by_q <= '0;
            dx_q <= DIR_POS;
            dy_q <= DIR_POS;
        end else begin
            bx_q <= bx_d;
            by_q <= by_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    // Bar indices wrap through the 8-entry table when NUM_BARS exceeds 8.
    assign x_ext  = 8'(x_idx);
    assign y_ext  = 8'(y_idx);
    assign in_box = ({1'b0, x_pix} >= {1'b0, bx_q}) &&
                    ({1'b0, x_pix} <  ({1'b0, bx_q} + BX_SIZE)) &&
                    ({1'b0, y_pix} >= {1'b0, by_q}) &&
                    ({1'b0, y_pix} <  ({1'b0, by_q} + BY_SIZE));

    // Pattern mux; blanking forces black.
    always_comb begin
        pix_color = '0;
        case (mode_active_q)
            MODE_SOLID:    pix_color = user_color;
            MODE_VBARS:    pix_color = expand(color_table(x_ext[2:0]));
            MODE_HBARS:    pix_color = expand(color_table(y_ext[2:0]));
            MODE_CHECKER:  pix_color = expand((x_pix[CHK_LOG2] ^ y_pix[CHK_LOG2]) ?
                                              color_table(3'd0) : color_table(3'd7));
            MODE_GRADIENT: begin
                pix_color.r = x_pix[XW-1 -: CW];
                pix_color.g = y_pix[YW-1 -: CW];
                pix_color.b = frame_cnt_q[FCW-1 -: CW];
            end
            MODE_BOX:      pix_color = expand(in_box ? color_table(3'd0) : color_table(3'd6));
            MODE_CYCLE:    pix_color = expand(color_table(frame_cnt_q[FCW-1 -: 3]));
            MODE_BLACK:    pix_color = '0;
            default:       pix_color = '0;
        endcase
        pixel_d = (h_blank | v_blank) ? '0 : pix_color;
    end

    // Frame-edge detect, mode, frame counter and output colour registers.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            v_blank_q     <= 1'b0;
            mode_active_q <= MODE_SOLID;
            frame_cnt_q   <= '0;
            pixel_q       <= '0;
        end else begin
            v_blank_q     <= v_blank;
            mode_active_q <= mode_active_d;
            frame_cnt_q   <= frame_cnt_d;
            pixel_q       <= pixel_d;
        end
    end

    assign pixel_color = pixel_q;
    assign mode_active = mode_active_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: a default-parameter instance plus a
// three-bar instance sharing the same stimulus.
module tb_vga_pattern_gen;

    logic        pixel_clk;
    logic        rst;
    logic [10:0] x_pix;
    logic [10:0] y_pix;
    logic        h_blank;
    logic        v_blank;
    logic [2:0]  mode_sel;
    logic [11:0] user_color;
    logic [11:0] pixel_color;
    logic [2:0]  mode_active;
    logic [7:0]  frame_cnt;
    logic [11:0] pixel_color3;
    logic [2:0]  mode_active3;
    logic [7:0]  frame_cnt3;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_fc;
    int boxes;

    vga_pattern_gen dut (
        .pixel_clk   (pixel_clk),
        .rst         (rst),
        .x_pix       (x_pix),
        .y_pix       (y_pix),
        .h_blank     (h_blank),
        .v_blank     (v_blank),
        .mode_sel    (mode_sel),
        .user_color  (user_color),
        .pixel_color (pixel_color),
        .mode_active (mode_active),
        .frame_cnt   (frame_cnt)
    );

    vga_pattern_gen #(.NUM_BARS(3)) dut3 (
        .pixel_clk   (pixel_clk),
        .rst         (rst),
        .x_pix       (x_pix),
        .y_pix       (y_pix),
        .h_blank     (h_blank),
        .v_blank     (v_blank),
        .mode_sel    (mode_sel),
        .user_color  (user_color),
        .pixel_color (pixel_color3),
        .mode_active (mode_active3),
        .frame_cnt   (frame_cnt3)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    // One v_blank rise followed by return to active video.
    task automatic frame_pulse();
        v_blank = 1'b1;
        tick();
        v_blank = 1'b0;
        tick();
        exp_fc = exp_fc + 8'd1;
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [11:0] exp);
        x_pix = 11'(x);
        y_pix = 11'(y);
        tick();
        check_eq(tag, 32'(pixel_color), 32'(exp));
    endtask

    initial begin
        rst        = 1'b1;
        x_pix      = '0;
        y_pix      = '0;
        h_blank    = 1'b0;
        v_blank    = 1'b0;
        mode_sel   = 3'd0;
        user_color = 12'h5A3;
        exp_fc     = 8'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset mid-line while showing vertical bars.
        mode_sel = 3'd1;
        frame_pulse();
        x_pix = 11'd5;
        tick();
        rst   = 1'b1;
        x_pix = 11'd6;
        tick();
        check_eq("rst_pixel", 32'(pixel_color), 32'h0);
        check_eq("rst_mode", 32'(mode_active), 32'd0);
        check_eq("rst_fcnt", 32'(frame_cnt), 32'd0);
        rst    = 1'b0;
        exp_fc = 8'd0;
        probe("solid_after_rst", 7, 0, 12'h5A3);
        frame_pulse();
        check_eq("mode1_latched", 32'(mode_active), 32'd1);
        check_eq("fcnt_1", 32'(frame_cnt), 32'(exp_fc));

        // Sweep a full line; check both bar layouts at their boundaries.
        for (int x = 0; x < 1024; x++) begin
            x_pix = 11'(x);
            tick();
            if (x == 0)    check_eq("vb8_x0", 32'(pixel_color), 32'hFFF);
            if (x == 127)  check_eq("vb8_x127", 32'(pixel_color), 32'hFFF);
            if (x == 128)  check_eq("vb8_x128", 32'(pixel_color), 32'hFF0);
            if (x == 895)  check_eq("vb8_x895", 32'(pixel_color), 32'h00F);
            if (x == 896)  check_eq("vb8_x896", 32'(pixel_color), 32'h000);
            if (x == 1023) check_eq("vb8_x1023", 32'(pixel_color), 32'h000);
            if (x == 0)    check_eq("vb3_x0", 32'(pixel_color3), 32'hFFF);
            if (x == 340)  check_eq("vb3_x340", 32'(pixel_color3), 32'hFFF);
            if (x == 341)  check_eq("vb3_x341", 32'(pixel_color3), 32'hFF0);
            if (x == 681)  check_eq("vb3_x681", 32'(pixel_color3), 32'hFF0);
            if (x == 682)  check_eq("vb3_x682", 32'(pixel_color3), 32'h0FF);
            if (x == 1023) check_eq("vb3_x1023", 32'(pixel_color3), 32'h0FF);
        end

        // Horizontal bars from a stepping y.
        mode_sel = 3'd2;
        frame_pulse();
        x_pix = 11'd0;
        for (int y = 0; y <= 200; y++) begin
            y_pix = 11'(y);
            tick();
            if (y == 95)  check_eq("hb_y95", 32'(pixel_color), 32'hFFF);
            if (y == 96)  check_eq("hb_y96", 32'(pixel_color), 32'hFF0);
            if (y == 192) check_eq("hb_y192", 32'(pixel_color), 32'h0FF);
        end

        // Mode change requested mid-frame waits for the frame edge.
        mode_sel = 3'd1;
        frame_pulse();
        mode_sel = 3'd3;
        tick();
        tick();
        tick();
        check_eq("mode_hold", 32'(mode_active), 32'd1);
        frame_pulse();
        check_eq("mode3_latched", 32'(mode_active), 32'd3);
        probe("chk_32_0", 32, 0, 12'hFFF);
        probe("chk_32_32", 32, 32, 12'h000);
        probe("chk_0_0", 0, 0, 12'h000);

        // Blanking forces black, output returns one cycle later.
        mode_sel = 3'd0;
        frame_pulse();
        user_color = 12'h5A3;
        h_blank    = 1'b1;
        probe("hblank", 10, 0, 12'h000);
        h_blank = 1'b0;
        probe("hblank_off", 10, 0, 12'h5A3);
        v_blank = 1'b1;
        probe("vblank", 10, 0, 12'h000);
        v_blank = 1'b0;
        exp_fc  = exp_fc + 8'd1;
        probe("vblank_off", 10, 0, 12'h5A3);

        // Frame counter wrap and colour cycling.
        mode_sel = 3'd6;
        frame_pulse();
        check_eq("fcnt_track", 32'(frame_cnt), 32'(exp_fc));
        while (exp_fc != 8'd31) frame_pulse();
        check_eq("cyc_fc31", 32'(pixel_color), 32'hFFF);
        frame_pulse();
        check_eq("cyc_fc32", 32'(pixel_color), 32'hFF0);
        check_eq("fcnt_32", 32'(frame_cnt), 32'd32);
        while (exp_fc != 8'd255) frame_pulse();
        check_eq("fcnt_255", 32'(frame_cnt), 32'd255);
        check_eq("cyc_fc255", 32'(pixel_color), 32'h000);
        frame_pulse();
        check_eq("fcnt_wrap", 32'(frame_cnt), 32'd0);
        check_eq("cyc_wrap", 32'(pixel_color), 32'hFFF);

        // Gradient at frame 1.
        mode_sel = 3'd4;
        frame_pulse();
        probe("grad", 1023, 767, 12'h750);

        // Bouncing box from a fresh reset.
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        exp_fc   = 8'd0;
        mode_sel = 3'd5;
        frame_pulse();
        boxes = 1;
        probe("box1_in", 4, 4, 12'hFFF);
        probe("box1_left", 3, 4, 12'h00F);
        probe("box1_right", 68, 4, 12'h00F);
        probe("box1_corner", 67, 67, 12'hFFF);
        while (boxes < 240) begin
            frame_pulse();
            boxes++;
        end
        probe("box240_in", 960, 452, 12'hFFF);
        probe("box240_left", 959, 452, 12'h00F);
        probe("box240_edge", 1023, 452, 12'hFFF);
        probe("box240_above", 960, 451, 12'h00F);
        probe("box240_bot", 960, 515, 12'hFFF);
        probe("box240_below", 960, 516, 12'h00F);
        frame_pulse();
        probe("box241_hold", 960, 448, 12'hFFF);
        frame_pulse();
        probe("box242_in", 956, 444, 12'hFFF);
        probe("box242_left", 955, 444, 12'h00F);
        probe("box242_r_in", 1019, 444, 12'hFFF);
        probe("box242_r_out", 1020, 444, 12'h00F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
